// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax denominator accumulator.
package softmax_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int popcount(input logic [31:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_LANES   = 4;
   localparam int DEF_GUARD_W = 4;
   localparam int SUM_W       = DEF_DATA_W + DEF_GUARD_W;
   localparam int CNT_W       = DEF_GUARD_W + 1;
   localparam int TREE_W      = DEF_DATA_W + clog2(DEF_LANES);

endpackage

// File: rtl/softmax_lane_adder_tree.sv
// Combinational sum of the kept lanes of one input beat.
module softmax_lane_adder_tree
   import softmax_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LANES  = 4,
   parameter int TREE_W = DATA_W + clog2(LANES)
) (
   input  logic [LANES*DATA_W-1:0] data_i,
   input  logic [LANES-1:0]        keep_i,
   output logic [TREE_W-1:0]       sum_o
);

   always_comb begin
      sum_o = '0;
      for (int k = 0; k < LANES; k++) begin
         if (keep_i[k]) sum_o = sum_o + TREE_W'(data_i[k*DATA_W +: DATA_W]);
      end
   end

endmodule

// File: rtl/softmax_sum_accumulator.sv
// Framed, saturating accumulator of exp values feeding the softmax divider.
module softmax_sum_accumulator
   import softmax_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int LANES   = 4,
   parameter int GUARD_W = 4,
   parameter int SHIFT   = 4,
   parameter int OUT_W   = 16
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic [LANES*DATA_W-1:0] in_data_i,
   input  logic [LANES-1:0]        in_keep_i,
   input  logic                    in_valid_i,
   input  logic                    in_last_i,
   output logic                    in_ready_o,
   input  logic                    clear_i,
   output logic [OUT_W-1:0]        sum_data_o,
   output logic [GUARD_W:0]        sum_count_o,
   output logic                    sum_ovf_o,
   output logic                    sum_valid_o,
   input  logic                    sum_ready_i
);

   localparam int ACC_W   = DATA_W + GUARD_W;
   localparam int CNTW    = GUARD_W + 1;
   localparam int TRW     = DATA_W + clog2(LANES);
   localparam int CNT_MAX = (1 << CNTW) - 1;

   state_e              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                in_ready_q;
   logic [TRW-1:0]      tree;
   logic [ACC_W:0]      acc_sum;
   logic [CNTW-1:0]     cnt_inc;
   int                  cnt_sum;
   logic                accept;
   logic [ACC_W+OUT_W-1:0] shifted;
   logic                hi_bits;

   softmax_lane_adder_tree #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .TREE_W (TRW)
   ) u_tree (
      .data_i (in_data_i),
      .keep_i (in_keep_i),
      .sum_o  (tree)
   );

   assign accept  = in_valid_i & in_ready_q;
   assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(tree);

   always_comb begin
      cnt_sum = int'(cnt_q) + popcount(32'(in_keep_i));
      cnt_inc = (cnt_sum > CNT_MAX) ? CNTW'(CNT_MAX) : CNTW'(cnt_sum);
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clear_i) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  // carry out of the widened add means the sum no longer fits
                  acc_d   = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
                  ovf_d   = ovf_q | acc_sum[ACC_W];
                  cnt_d   = cnt_inc;
                  state_d = in_last_i ? DONE : ACCUM;
               end
            end
            DONE: begin
               if (sum_ready_i) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         in_ready_q <= (state_d != DONE);
      end
   end

   // accumulator stays frozen in DONE, so the result is held until taken
   assign shifted     = {{OUT_W{1'b0}}, acc_q} >> SHIFT;
   assign hi_bits     = |(shifted >> OUT_W);
   assign sum_data_o  = hi_bits ? '1 : shifted[OUT_W-1:0];
   assign sum_ovf_o   = ovf_q | hi_bits;
   assign sum_count_o = cnt_q;
   assign sum_valid_o = (state_q == DONE);
   assign in_ready_o  = in_ready_q;

endmodule
